// File: rtl/seq_mul_pkg.sv
// Shared types and constants for the seq_mul_param iterative multiplier.
// Optional signed mode is controlled by the SEQ_MUL_SIGNED_EN macro.
package seq_mul_pkg;

  localparam int MAX_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // The counter has to reach WIDTH itself, so it needs WIDTH+1 codes.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_mul_addsub.sv
// (WIDTH+1)-bit ripple adder/subtractor built from fa cells, producing the
// low WIDTH sum bits and the bit shifted into the accumulator MSB.
// When SEQ_MUL_SIGNED_EN is undefined the parent ties sub and sign_ext low.
module fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module seq_mul_addsub #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             add_en,
  input  logic             sub,
  input  logic             sign_ext,
  output logic [WIDTH-1:0] sum,
  output logic             shift_in
);

  logic [WIDTH:0] a_ext;
  logic [WIDTH:0] b_ext;
  logic [WIDTH:0] b_sel;
  logic [WIDTH:0] s_full;
  logic [WIDTH+1:0] carry;

  // Sign extension to WIDTH+1 bits keeps the signed sum from ever overflowing,
  // so its top bit is the true sign; in unsigned mode it is the carry.
  assign a_ext = {sign_ext & a[WIDTH-1], a};
  assign b_ext = {sign_ext & b[WIDTH-1], b};
  assign b_sel = sub ? ~b_ext : (add_en ? b_ext : '0);
  assign carry[0] = sub;

  genvar i;
  generate
    for (i = 0; i <= WIDTH; i++) begin : g_fa
      fa u_fa (
        .a    (a_ext[i]),
        .b    (b_sel[i]),
        .cin  (carry[i]),
        .s    (s_full[i]),
        .cout (carry[i+1])
      );
    end
  endgenerate

  assign sum      = s_full[WIDTH-1:0];
  assign shift_in = s_full[WIDTH];

endmodule

// File: rtl/seq_mul_param.sv
// Parametrised shift-add multiplier, one partial product per clock, with a
// start/busy/done handshake. SEQ_MUL_SIGNED_EN adds an is_signed input.
module seq_mul_param
  import seq_mul_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = cnt_width(WIDTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   mul_a,
  input  logic [WIDTH-1:0]   mul_b,
`ifdef SEQ_MUL_SIGNED_EN
  input  logic               is_signed,
`endif
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);

  generate
    if (WIDTH < 2 || WIDTH > MAX_WIDTH) begin : g_bad_width
      $error("seq_mul_param: WIDTH out of range");
    end
  endgenerate

  state_t state, state_next;

  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_step;
  logic [CNT_W-1:0]   count;
  logic               load;
  logic               step;
  logic               last;
  logic               signed_mode;
  logic               sub;
  logic [WIDTH-1:0]   sum;
  logic               shift_in;

`ifdef SEQ_MUL_SIGNED_EN
  logic signed_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      signed_q <= 1'b0;
    end else if (load) begin
      signed_q <= is_signed;
    end
  end

  assign signed_mode = signed_q;
`else
  assign signed_mode = 1'b0;
`endif

  assign last = (count == CNT_W'(WIDTH - 1));
  // The multiplier MSB carries negative weight, hence subtract on the last step.
  assign sub  = signed_mode & last & acc[0];

  seq_mul_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a        (acc[2*WIDTH-1:WIDTH]),
    .b        (mcand),
    .add_en   (acc[0]),
    .sub      (sub),
    .sign_ext (signed_mode),
    .sum      (sum),
    .shift_in (shift_in)
  );

  assign acc_step = {shift_in, sum, acc[WIDTH-1:1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // prod is only written on the step that enters DONE, so it holds otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand <= '0;
      acc   <= '0;
      count <= '0;
      prod  <= '0;
    end else if (load) begin
      mcand <= mul_a;
      acc   <= {{WIDTH{1'b0}}, mul_b};
      count <= '0;
    end else if (step) begin
      acc   <= acc_step;
      count <= count + 1'b1;
      if (last) begin
        prod <= acc_step;
      end
    end
  end

endmodule

// File: tb/tb_seq_mul_param.sv
// Self-checking bench for seq_mul_param at WIDTH=8 and WIDTH=16.
// Signed-mode vectors are added when SEQ_MUL_SIGNED_EN is defined.
module tb_seq_mul_param;

  logic        clk = 1'b0;
  logic        reset;
  logic        start8, start16;
  logic [7:0]  a8, b8;
  logic [15:0] a16, b16;
  logic        busy8, done8, busy16, done16;
  logic [15:0] prod8;
  logic [31:0] prod16;
  logic        sgn8, sgn16;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_mul_param #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .reset     (reset),
    .start     (start8),
    .mul_a     (a8),
    .mul_b     (b8),
`ifdef SEQ_MUL_SIGNED_EN
    .is_signed (sgn8),
`endif
    .busy      (busy8),
    .done      (done8),
    .prod      (prod8)
  );

  seq_mul_param #(.WIDTH(16)) dut16 (
    .clk       (clk),
    .reset     (reset),
    .start     (start16),
    .mul_a     (a16),
    .mul_b     (b16),
`ifdef SEQ_MUL_SIGNED_EN
    .is_signed (sgn16),
`endif
    .busy      (busy16),
    .done      (done16),
    .prod      (prod16)
  );

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        sgn;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[$];

  // Reference: plain integer multiply, truncated to the 2*w product width.
  function automatic logic [63:0] refMul(input int w, input logic [31:0] a,
                                         input logic [31:0] b, input logic sgn);
    longint sa, sb, p;
    logic [63:0] mask;
    sa = longint'(a);
    sb = longint'(b);
    if (sgn) begin
      if (a[w-1]) sa = sa - (longint'(1) << w);
      if (b[w-1]) sb = sb - (longint'(1) << w);
    end
    p    = sa * sb;
    mask = (64'd1 << (2 * w)) - 64'd1;
    return 64'(p) & mask;
  endfunction

  function automatic logic busyOf(input bit wide);
    return wide ? busy16 : busy8;
  endfunction

  function automatic logic doneOf(input bit wide);
    return wide ? done16 : done8;
  endfunction

  function automatic logic [63:0] prodOf(input bit wide);
    return wide ? 64'(prod16) : 64'(prod8);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Presents one operation for exactly one edge, then drops start.
  task automatic applyStimulus(input bit wide, input logic [31:0] a,
                               input logic [31:0] b, input logic sgn);
    if (wide) begin
      a16 = a[15:0]; b16 = b[15:0]; sgn16 = sgn; start16 = 1'b1;
    end else begin
      a8 = a[7:0]; b8 = b[7:0]; sgn8 = sgn; start8 = 1'b1;
    end
    tick();
    start8  = 1'b0;
    start16 = 1'b0;
  endtask

  task automatic waitDone(input bit wide, input int already, output int lat);
    lat = already;
    while (!doneOf(wide) && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic runOp(input bit wide, input logic [31:0] a, input logic [31:0] b,
                       input logic sgn, input string tag, input logic [63:0] exp);
    int lat;
    applyStimulus(wide, a, b, sgn);
    checkOutput({tag, " busy"}, 64'(busyOf(wide)), 64'd1);
    waitDone(wide, 0, lat);
    checkOutput({tag, " latency"}, 64'(lat), wide ? 64'd16 : 64'd8);
    checkOutput({tag, " prod"}, prodOf(wide), exp);
  endtask

  task automatic countDones(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (done8) n++;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int lat, n;
    logic [31:0] ra, rb;
    logic rs;

    reset = 1'b1;
    start8 = 1'b0; start16 = 1'b0;
    a8 = '0; b8 = '0; a16 = '0; b16 = '0;
    sgn8 = 1'b0; sgn16 = 1'b0;

    vecs.push_back('{8'h0D, 8'h0B, 1'b0, 16'h008F});
    vecs.push_back('{8'hFF, 8'hFF, 1'b0, 16'hFE01});
    vecs.push_back('{8'h10, 8'h10, 1'b0, 16'h0100});
    vecs.push_back('{8'h03, 8'h07, 1'b0, 16'h0015});
    vecs.push_back('{8'h00, 8'h5A, 1'b0, 16'h0000});
    vecs.push_back('{8'h80, 8'h7F, 1'b0, 16'h3F80});
    vecs.push_back('{8'h01, 8'hFF, 1'b0, 16'h00FF});
`ifdef SEQ_MUL_SIGNED_EN
    vecs.push_back('{8'hFF, 8'hFF, 1'b1, 16'h0001});
    vecs.push_back('{8'h80, 8'h7F, 1'b1, 16'hC080});
    vecs.push_back('{8'h7F, 8'h80, 1'b1, 16'hC080});
    vecs.push_back('{8'h80, 8'h80, 1'b1, 16'h4000});
`endif

    tick();
    tick();
    checkOutput("reset busy", 64'(busy8), 64'd0);
    checkOutput("reset done", 64'(done8), 64'd0);
    checkOutput("reset prod", 64'(prod8), 64'd0);
    reset = 1'b0;
    tick();

    foreach (vecs[i]) begin
      runOp(1'b0, 32'(vecs[i].a), 32'(vecs[i].b), vecs[i].sgn, $sformatf("vec%0d", i),
            64'(vecs[i].exp));
      tick();
      checkOutput($sformatf("vec%0d done drop", i), 64'(done8), 64'd0);
      checkOutput($sformatf("vec%0d prod hold", i), 64'(prod8), 64'(vecs[i].exp));
    end

    // Back-to-back: the next start is presented on the done cycle.
    runOp(1'b0, 32'hFF, 32'hFF, 1'b0, "b2b first", 64'hFE01);
    applyStimulus(1'b0, 32'h00, 32'h5A, 1'b0);
    checkOutput("b2b accept busy", 64'(busy8), 64'd1);
    tick(); tick(); tick();
    checkOutput("b2b prod held", 64'(prod8), 64'hFE01);
    waitDone(1'b0, 3, lat);
    checkOutput("b2b second latency", 64'(lat), 64'd8);
    checkOutput("b2b second prod", 64'(prod8), 64'h0000);
    tick();

    // Start while busy must be ignored.
    applyStimulus(1'b0, 32'h10, 32'h10, 1'b0);
    tick(); tick(); tick();
    a8 = 8'h02; b8 = 8'h02; start8 = 1'b1;
    tick();
    start8 = 1'b0; a8 = '0; b8 = '0;
    waitDone(1'b0, 4, lat);
    checkOutput("ignore latency", 64'(lat), 64'd8);
    checkOutput("ignore prod", 64'(prod8), 64'h0100);
    countDones(12, n);
    checkOutput("ignore extra done", 64'(n), 64'd0);
    checkOutput("ignore prod kept", 64'(prod8), 64'h0100);

    // Asynchronous reset in the middle of an operation.
    applyStimulus(1'b0, 32'hAA, 32'h55, 1'b0);
    tick(); tick(); tick();
    checkOutput("abort busy before", 64'(busy8), 64'd1);
    #2 reset = 1'b1;
    #1;
    checkOutput("abort busy", 64'(busy8), 64'd0);
    checkOutput("abort done", 64'(done8), 64'd0);
    checkOutput("abort prod", 64'(prod8), 64'd0);
    tick();
    reset = 1'b0;
    countDones(12, n);
    checkOutput("abort no done", 64'(n), 64'd0);
    runOp(1'b0, 32'h03, 32'h07, 1'b0, "after abort", 64'h0015);
    tick();

    for (int i = 0; i < 20; i++) begin
      ra = 32'($urandom_range(0, 255));
      rb = 32'($urandom_range(0, 255));
`ifdef SEQ_MUL_SIGNED_EN
      rs = 1'($urandom_range(0, 1));
`else
      rs = 1'b0;
`endif
      runOp(1'b0, ra, rb, rs, $sformatf("rnd8 %0h*%0h s%0d", ra, rb, rs),
            refMul(8, ra, rb, rs));
      if (($urandom & 1) == 0) tick();
    end

    runOp(1'b1, 32'hFFFF, 32'hFFFF, 1'b0, "w16 max", 64'hFFFE0001);
    tick();
    for (int i = 0; i < 6; i++) begin
      ra = 32'($urandom_range(0, 65535));
      rb = 32'($urandom_range(0, 65535));
`ifdef SEQ_MUL_SIGNED_EN
      rs = 1'($urandom_range(0, 1));
`else
      rs = 1'b0;
`endif
      runOp(1'b1, ra, rb, rs, $sformatf("rnd16 %0h*%0h s%0d", ra, rb, rs),
            refMul(16, ra, rb, rs));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seq_mul_param.md
Name: seq_mul_param

Overview:
Parametrised iterative shift-add multiplier, the successor to the fixed 8x8 sequential multiplier. It multiplies two WIDTH-bit operands into a 2*WIDTH-bit product, one partial-product step per clock. A start/busy/done handshake lets a controller or datapath issue operations back to back. The block sits beside the ALU as a multi-cycle execution unit.

Parameters:
WIDTH, 8, operand width in bits (legal 2..32); product is 2*WIDTH bits.
CNT_W, $clog2(WIDTH+1), iteration counter width (derived; not overridden).

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  request; sampled only when busy=0
mul_a  input  WIDTH  multiplicand; sampled with accepted start
mul_b  input  WIDTH  multiplier; sampled with accepted start
busy  output  1  operation in progress
done  output  1  one-cycle pulse: prod valid
prod  output  2*WIDTH  product; held until next accepted start

Behaviour:
- Reset (async, any time including mid-operation): state=IDLE, busy=0, done=0, prod=0, counter=0, operand registers=0. No done is issued for an aborted operation.
- States: IDLE, RUN, DONE.
- IDLE/DONE with start=1 (edge 0): latch mul_a into the multiplicand register. Load acc = {WIDTH zeros, mul_b}, counter=0, go to RUN, busy=1.
- RUN, each edge: if acc[0]=1, acc upper half + multiplicand forms a (WIDTH+1)-bit sum, otherwise upper half + 0. acc <= {sum, acc[WIDTH-1:1]}, with the sum carry shifted in as the MSB. counter++.
- After the WIDTH-th RUN edge (edge WIDTH): go to DONE. busy=0, done=1, prod=acc. Latency from the accepting edge to done high is exactly WIDTH cycles.
- DONE lasts one cycle. With no start it returns to IDLE and done drops. With start=1 it accepts the new operation directly (back-to-back; done and accept coincide).
- start while busy=1: ignored, no queuing, inputs not sampled.
- prod updates only on entering DONE. It is stable through IDLE and through the following RUN until the next DONE.
- Unsigned arithmetic. No overflow is possible: the full 2*WIDTH product is always produced.
- Zero operands are not short-circuited; latency is always WIDTH.

Optional Feature:
Macro SEQ_MUL_SIGNED_EN.
- Defined: adds input port is_signed (1 bit, sampled with start).
  - When is_signed=1, operands are two's complement.
  - Each step shifts in the sign bit of the (WIDTH+1)-bit signed sum, not the carry.
  - On the final iteration, when acc[0]=1, the multiplicand is subtracted instead of added.
  - prod is the 2*WIDTH-bit two's-complement result. Latency is unchanged.
  - When is_signed=0, behaviour is identical to the unsigned mode.
- Undefined: no is_signed port; unsigned only. Gate count matches the plain adder path.

Decomposition:
- Package seq_mul_pkg holds:
  - the state enum typedef (IDLE, RUN, DONE);
  - a localparam function for counter width;
  - a shared constant MAX_WIDTH=32 for the parameter check.
- One sub-module, seq_mul_addsub: (WIDTH+1)-bit adder/subtractor producing sum and shift-in bit. Built from the existing fa cells via generate; sub/signed inputs are tied off when SEQ_MUL_SIGNED_EN is undefined.
- The controller FSM, counter and accumulator stay in seq_mul_param.

Test Plan:
- WIDTH=8, start with mul_a=0x0D, mul_b=0x0B -> busy for 8 cycles, done pulse at edge 8, prod=0x008F.
- WIDTH=8, 0xFF*0xFF -> prod=0xFE01. Back-to-back start asserted on the done cycle with 0x00*0x5A -> second done 8 cycles later with prod=0x0000, and prod=0xFE01 held in between.
- WIDTH=8, start re-asserted with 0x02*0x02 during busy -> ignored; first result 0x10*0x10=0x0100 completes unchanged, only one done pulse.
- Reset asserted at cycle 4 of 0xAA*0x55 -> busy, done and prod go to 0 immediately (asynchronously). No done follows; a new start afterwards computes 0x03*0x07=0x0015 correctly.
- WIDTH=16, 0xFFFF*0xFFFF -> done exactly 16 cycles after accept, prod=0xFFFE0001.
- SEQ_MUL_SIGNED_EN, WIDTH=8, is_signed=1 -> 0xFF*0xFF=0x0001 and 0x80*0x7F=0xC080. With is_signed=0, 0x80*0x7F=0x3F80.
